// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master round-robin arbiter in front of one native-interface
//            memory slave (PicoRV32-style valid/ready bus). Each granted
//            request is registered toward the slave. Read data returns with a
//            one-cycle ready pulse. A stalled slave access is aborted after
//            TIMEOUT cycles and completes with ERR_DATA.
// Ports    : clock, reset             - clock, async active-high reset
//            m0_* / m1_*              - master request ports (valid, instr,
//                                       addr, wdata, wstrb -> ready, rdata)
//            s_*                      - slave request/response port
//            err                      - sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        err
);

  localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic                 prio_q,    prio_d;
  logic                 gnt_q,     gnt_d;
  logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
  logic [31:0]          rdata_q,   rdata_d;
  logic                 err_q,     err_d;
  logic                 s_valid_q, s_valid_d;
  logic                 s_instr_q, s_instr_d;
  logic [31:0]          s_addr_q,  s_addr_d;
  logic [31:0]          s_wdata_q, s_wdata_d;
  logic [3:0]           s_wstrb_q, s_wstrb_d;
  logic                 m0_ready_q, m0_ready_d;
  logic                 m1_ready_q, m1_ready_d;

  // Winner when in IDLE: a lone requester wins outright, a tie goes to prio.
  logic w_win;
  assign w_win = (m0_valid && m1_valid) ? prio_q : ~m0_valid;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    s_valid_d  = s_valid_q;
    s_instr_d  = s_instr_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          gnt_d     = w_win;
          cnt_d     = '0;
          s_instr_d = w_win ? m1_instr : m0_instr;
          s_addr_d  = w_win ? m1_addr  : m0_addr;
          s_wdata_d = w_win ? m1_wdata : m0_wdata;
          s_wstrb_d = w_win ? m1_wstrb : m0_wstrb;
          s_valid_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // A slave completion in the last allowed cycle beats the abort.
        if (s_ready) begin
          rdata_d    = s_rdata;
          s_valid_d  = 1'b0;
          m0_ready_d = ~gnt_q;
          m1_ready_d = gnt_q;
          state_d    = ST_RESP;
        end else if (cnt_q == c_cnt_last) begin
          rdata_d    = ERR_DATA;
          err_d      = 1'b1;
          s_valid_d  = 1'b0;
          m0_ready_d = ~gnt_q;
          m1_ready_d = gnt_q;
          state_d    = ST_RESP;
        end else if (cnt_q != c_cnt_max) begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_RESP: begin
        prio_d  = ~gnt_q;
        state_d = ST_IDLE;
      end
      default: begin
        s_valid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      s_valid_q  <= 1'b0;
      s_instr_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      s_valid_q  <= s_valid_d;
      s_instr_q  <= s_instr_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_instr  = s_instr_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  // Both masters see one shared read-data register.
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter that shares one native-interface memory slave (the testbench `mem` SRAM model or an on-chip SRAM) between two PicoRV32-style bus masters. Examples are a `Picorv32` core plus a DMA/loader, or two cores in a dual-hart test system. It registers each granted request toward the slave, returns read data with a one-cycle ready pulse, and aborts a stalled slave access after a programmable timeout so that a broken slave cannot hang a simulation silently.

## Interface
- `TIMEOUT`, 255: maximum cycles `s_valid` may wait for `s_ready` before abort; legal range 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an aborted access.
- `clock`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_valid`, `m1_valid`  in  1  request; held high until the matching `mN_ready`.
- `m0_instr`, `m1_instr`  in  1  instruction-fetch qualifier.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write strobes; 0 = read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data; both ports are driven from one shared register and are meaningful only while the matching ready is high.
- `s_valid`  out  1  request to slave.
- `s_instr`  out  1  forwarded instr qualifier.
- `s_addr`  out  32  forwarded address.
- `s_wdata`  out  32  forwarded write data.
- `s_wstrb`  out  4  forwarded strobes.
- `s_ready`  in  1  slave completion.
- `s_rdata`  in  32  slave read data, valid with `s_ready`.
- `err`  out  1  sticky: set by any timeout abort, cleared only by reset.

## Operation
- State machine with three states:
  - IDLE: if any `mN_valid` is high, select the winner, latch its `instr/addr/wdata/wstrb` into the slave-side registers, record `gnt` = winner, clear the timeout counter, and go to REQ. Otherwise stay in IDLE.
  - REQ: `s_valid` = 1, and the slave-side registers stay frozen.
    - If `s_ready` is high: latch `s_rdata` into the rdata register, go to RESP.
    - Else if the counter equals `TIMEOUT-1`: latch `ERR_DATA`, set `err`, go to RESP.
    - Else: increment the counter.
  - RESP: `m[gnt]_ready` = 1 for exactly one cycle, set `prio` = ~`gnt`, go to IDLE.
- Arbitration in IDLE:
  - Only one master valid: that master wins.
  - Both valid: master `prio` wins.
  - `prio` resets to 0, so m0 is favoured after reset.
- Inputs of the non-granted master are ignored until the next IDLE.
- In REQ and RESP, a `valid` that drops is ignored; the transaction completes regardless.
- The granted master drops `valid` on the edge where it samples `ready`. Because of this, IDLE never re-grants the transaction that just completed.
- Write transactions also return through RESP. The rdata register is loaded with `s_rdata` either way, and its content is don't-care for writes.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide, saturating, and is active only in REQ.

## Timing
- Reset values:
  - All outputs 0.
  - state = IDLE, `prio` = 0, `gnt` = 0, counter = 0, rdata register = 0.
- Reset is asynchronous and takes effect mid-transaction. After reset, `s_valid` and `mN_ready` are low, and no completion is delivered for the aborted access.
- Handshake latency:
  - `mN_valid` sampled in IDLE at cycle t.
  - `s_valid` high from t+1.
  - `s_ready` first accepted at t+1.
  - `mN_ready` at t+2.
  - IDLE at t+3.
- Minimum 3 cycles per transaction; back-to-back alternating masters sustain one transaction per 3 cycles.
- A zero-wait slave sees `s_valid` for exactly 1 cycle.
- `s_ready` arriving while `s_valid` is low is ignored.
- Timeout:
  - `s_valid` stays high for exactly `TIMEOUT` cycles.
  - `mN_ready` with `ERR_DATA` follows on the next cycle.
  - `s_ready` in the final REQ cycle has priority over the abort.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single read: m0 reads addr 0x100, slave returns 0x12345678 after 2 wait cycles. Required:
  - `s_addr` = 0x100, `s_wstrb` = 0, `s_valid` for 3 cycles.
  - `m0_ready` 1 cycle later with `m0_rdata` = 0x12345678.
  - `m1_ready` never asserts.
- Simultaneous requests after reset: m0 and m1 are both valid, with both re-requesting immediately each time. Required:
  - Grant order m0, m1, m0, m1.
  - Each `mN_ready` pulse is exactly 1 cycle.
  - Slave addresses alternate accordingly.
- Write forwarding: m1 writes 0xA5A5A5A5 with `wstrb` = 4'b0011 to 0x2004. Required:
  - The slave sees identical `addr/wdata/wstrb` held stable for every `s_valid` cycle.
  - `m1_ready` pulses once.
  - `err` = 0.
- Timeout: `TIMEOUT` = 4, slave never asserts ready, m0 reads. Required:
  - `s_valid` high for exactly 4 cycles.
  - `m0_ready` pulses with `m0_rdata` = 0xDEADBEEF.
  - `err` goes to 1 and stays at 1 through later successful transactions.
- Ready on last cycle: `TIMEOUT` = 4, `s_ready` arrives in the 4th REQ cycle with data 0x0000CAFE. Required: `m0_rdata` = 0x0000CAFE, `err` remains 0.
- Reset mid-REQ: assert `reset` asynchronously between clock edges while `s_valid` = 1. Required:
  - `s_valid` and all ready outputs go to 0 immediately.
  - After release, the first simultaneous request grants m0.
